// File: rtl/cmsdk_apb3_eg_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmsdk_apb3_eg_master_pkg
//  Description : Shared definitions for the APB3 initiator. Holds the
//                transfer state encoding and the helper that sizes the
//                ACCESS-phase wait-state counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmsdk_apb3_eg_master_pkg;

    // Transfer state encoding
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    // Counter must be able to represent TIMEOUT_CYCLES itself (its saturation
    // value); a disabled timeout still gets a 1-bit vector so no zero-width
    // signals appear anywhere.
    function automatic int timer_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmsdk_apb3_eg_master_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cmsdk_apb3_eg_master_timer
//  Description : Saturating wait-state counter for the ACCESS phase.
//                o_expired is high while the count equals TIMEOUT_CYCLES-1,
//                i.e. on the last stalled ACCESS cycle allowed.
//                TIMEOUT_CYCLES = 0 removes the counter; o_expired is 0.
//  Ports       : clk        - clock
//                rst        - synchronous active-high reset
//                i_clear    - clear count (start of a transfer)
//                i_enable   - count one stalled ACCESS cycle
//                o_expired  - timeout limit reached
//  Revision    : 1.0 - initial release
// ============================================================================
module cmsdk_apb3_eg_master_timer
    import cmsdk_apb3_eg_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int c_CNT_W = timer_width(TIMEOUT_CYCLES);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
            localparam logic [c_CNT_W-1:0] c_MAX  = c_CNT_W'(TIMEOUT_CYCLES);

            logic [c_CNT_W-1:0] r_count;

            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_count <= '0;
                end else if (i_enable && (r_count != c_MAX)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_expired = (r_count == c_LAST);
        end else begin : g_no_timeout
            logic w_unused;
            assign w_unused  = ^{clk, rst, i_clear, i_enable};
            assign o_expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cmsdk_apb3_eg_master.sv
`default_nettype none
// ============================================================================
//  Module      : cmsdk_apb3_eg_master
//  Description : APB3 initiator. Converts one valid/ready command into a
//                single APB3 transfer (SETUP then ACCESS with PREADY wait
//                states) and returns read data / error status on a
//                valid/ready response channel. One transfer outstanding.
//  Ports       : PCLK, PRESET          - clock, synchronous active-high reset
//                cmd_valid/cmd_ready   - command handshake
//                cmd_write/addr/wdata  - command payload
//                rsp_valid/rsp_ready   - response handshake
//                rsp_rdata/err/timeout - response payload
//                PSEL..PWDATA          - APB3 requester outputs
//                PRDATA/PREADY/PSLVERR - APB3 completer inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module cmsdk_apb3_eg_master
    import cmsdk_apb3_eg_master_pkg::*;
#(
    parameter int ADDRWIDTH      = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    // command channel
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [31:0]          cmd_wdata,
    // response channel
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    // APB3 requester
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    logic [1:0]           r_state;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [ADDRWIDTH-1:0] r_paddr;
    logic [31:0]          r_pwdata;
    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_rdata;
    logic                 r_rsp_err;
    logic                 r_rsp_timeout;

    logic                 w_timer_clear;
    logic                 w_timer_enable;
    logic                 w_expired;

    // Counter restarts during SETUP so every transfer gets the full budget;
    // it only advances on stalled ACCESS cycles.
    assign w_timer_clear  = (r_state == c_SETUP);
    assign w_timer_enable = (r_state == c_ACCESS) && !PREADY;

    cmsdk_apb3_eg_master_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (PCLK),
        .rst       (PRESET),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= c_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // cmd_ready is high throughout IDLE
                    if (cmd_valid) begin
                        r_paddr   <= cmd_addr;
                        r_pwrite  <= cmd_write;
                        r_pwdata  <= cmd_write ? cmd_wdata : 32'h0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= c_ACCESS;
                end
                c_ACCESS: begin
                    // PREADY takes priority over a timeout in the same cycle
                    if (PREADY) begin
                        r_rsp_rdata   <= r_pwrite ? 32'h0 : PRDATA;
                        r_rsp_err     <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= c_RESP;
                    end else if (w_expired) begin
                        r_rsp_rdata   <= 32'h0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == c_IDLE);

    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;

    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_apb3_eg_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmsdk_apb3_eg_master
//  Description : Self-checking bench for the APB3 initiator. Stimulus pushes
//                the hand-computed response into a queue; a monitor pops and
//                compares on every response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmsdk_apb3_eg_master;

    localparam int AW = 12;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    cmsdk_apb3_eg_master #(
        .ADDRWIDTH      (AW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // Scoreboard monitor: one pop per response handshake
    always @(negedge PCLK) begin
        if (!PRESET && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rdata=%0h err=%0b to=%0b expected no response",
                         rsp_rdata, rsp_err, rsp_timeout);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata",   rsp_rdata,   mon_e.rdata);
                chk("rsp_err",     rsp_err,     mon_e.err);
                chk("rsp_timeout", rsp_timeout, mon_e.to);
            end
        end
    end

    // Present a command in IDLE, optionally queue its expected response,
    // and check the SETUP cycle that follows.
    task automatic start_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                             input bit do_push, input logic [31:0] e_rdata, input logic e_err,
                             input logic e_to);
        rsp_t e;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        chk("cmd_ready_accept", cmd_ready, 1);
        if (do_push) begin
            e.rdata = e_rdata;
            e.err   = e_err;
            e.to    = e_to;
            exp_q.push_back(e);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = 32'h5555_AAAA;
        cmd_addr  = 12'hFFF;
        chk("setup_psel",    PSEL,      1);
        chk("setup_penable", PENABLE,   0);
        chk("setup_paddr",   PADDR,     addr);
        chk("setup_pwrite",  PWRITE,    wr);
        chk("setup_pwdata",  PWDATA,    wr ? wdata : 32'h0);
        chk("setup_cmd_rdy", cmd_ready, 0);
    endtask

    // From SETUP: `waits` stalled ACCESS cycles, then PREADY with the data.
    task automatic access_phase(input int waits, input logic [31:0] rdata, input logic slverr,
                                input logic [AW-1:0] addr);
        PREADY  = 1'b0;
        PRDATA  = 32'hBAD0_0000;
        PSLVERR = 1'b1;
        tick();
        for (int i = 0; i < waits; i++) begin
            chk("access_wait_psel", PSEL,    1);
            chk("access_wait_pen",  PENABLE, 1);
            chk("access_wait_addr", PADDR,   addr);
            tick();
        end
        PREADY  = 1'b1;
        PRDATA  = rdata;
        PSLVERR = slverr;
        chk("access_psel", PSEL,    1);
        chk("access_pen",  PENABLE, 1);
        chk("access_addr", PADDR,   addr);
        tick();
        PREADY  = 1'b0;
        PRDATA  = 32'hBAD0_0001;
        PSLVERR = 1'b1;
        chk("resp_valid", rsp_valid, 1);
        chk("resp_psel",  PSEL,      0);
        chk("resp_pen",   PENABLE,   0);
    endtask

    task automatic finish_rsp;
        tick();
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        PRESET = 1'b1;
        tick();
        tick();
        chk("rst_psel",      PSEL,        0);
        chk("rst_penable",   PENABLE,     0);
        chk("rst_pwrite",    PWRITE,      0);
        chk("rst_paddr",     PADDR,       0);
        chk("rst_pwdata",    PWDATA,      0);
        chk("rst_rsp_valid", rsp_valid,   0);
        chk("rst_rsp_rdata", rsp_rdata,   0);
        chk("rst_rsp_err",   rsp_err,     0);
        chk("rst_rsp_to",    rsp_timeout, 0);
        chk("rst_cmd_ready", cmd_ready,   1);
        PRESET = 1'b0;
        tick();

        // 1: write, zero wait states, PRDATA junk must not leak into rdata
        start_cmd(1'b1, 12'h010, 32'hA5A5_0001, 1'b1, 32'h0, 1'b0, 1'b0);
        access_phase(0, 32'hDEAD_BEEF, 1'b0, 12'h010);
        finish_rsp();

        // 2: read with 3 wait states
        start_cmd(1'b0, 12'h3F0, 32'h1111_2222, 1'b1, 32'h0000_0004, 1'b0, 1'b0);
        access_phase(3, 32'h0000_0004, 1'b0, 12'h3F0);
        finish_rsp();

        // 3: read with PSLVERR; next command blocked until rsp_ready
        rsp_ready = 1'b0;
        start_cmd(1'b0, 12'h044, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
        access_phase(0, 32'h0BAD_F00D, 1'b1, 12'h044);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h055;
        for (int i = 0; i < 2; i++) begin
            chk("err_hold_cmd_ready", cmd_ready, 0);
            chk("err_hold_psel",      PSEL,      0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        start_cmd(1'b0, 12'h055, 32'h0, 1'b1, 32'h0000_0055, 1'b0, 1'b0);
        access_phase(0, 32'h0000_0055, 1'b0, 12'h055);
        finish_rsp();

        // 4a: timeout with PREADY held low for 4 ACCESS cycles
        start_cmd(1'b0, 12'h100, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        PREADY  = 1'b0;
        PRDATA  = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_access_psel", PSEL,    1);
            chk("to_access_pen",  PENABLE, 1);
        end
        tick();
        chk("to_psel_drop", PSEL,      0);
        chk("to_pen_drop",  PENABLE,   0);
        chk("to_rsp_valid", rsp_valid, 1);
        finish_rsp();

        // 4b: PREADY on the 4th ACCESS cycle beats the timeout
        start_cmd(1'b0, 12'h104, 32'h0, 1'b1, 32'h0000_00A4, 1'b0, 1'b0);
        access_phase(3, 32'h0000_00A4, 1'b0, 12'h104);
        finish_rsp();

        // 5: rsp_ready low for 5 cycles with a new command waiting
        rsp_ready = 1'b0;
        start_cmd(1'b1, 12'h3FC, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 1'b0);
        access_phase(1, 32'hFFFF_FFFF, 1'b0, 12'h3FC);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h0C0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", rsp_valid,   1);
            chk("stall_rsp_rdata", rsp_rdata,   0);
            chk("stall_rsp_err",   rsp_err,     0);
            chk("stall_rsp_to",    rsp_timeout, 0);
            chk("stall_cmd_ready", cmd_ready,   0);
            chk("stall_psel",      PSEL,        0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        start_cmd(1'b0, 12'h0C0, 32'h0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
        access_phase(0, 32'hCAFE_0001, 1'b0, 12'h0C0);
        finish_rsp();

        // 6: reset while the slave stalls in ACCESS; no response expected
        start_cmd(1'b0, 12'h200, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        PREADY = 1'b0;
        tick();
        tick();
        chk("prerst_pen", PENABLE, 1);
        PRESET = 1'b1;
        tick();
        chk("midrst_psel",      PSEL,      0);
        chk("midrst_pen",       PENABLE,   0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        PRESET = 1'b0;
        chk("midrst_cmd_ready", cmd_ready, 1);
        tick();
        chk("postrst_psel",      PSEL,      0);
        chk("postrst_rsp_valid", rsp_valid, 0);

        tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
